// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment bus reader.
// Holds the active-low glyph constants (segments {g,f,e,d,c,b,a}), the
// capture FSM encoding and the digit count.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } fsm_t;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational glyph decoder: active-low 7-segment pattern -> hex nibble.
// Ports:
//   seg_i      7-bit pattern {g,f,e,d,c,b,a}, active-low
//   nibble_o   decoded hex value (0 for blank or unknown patterns)
//   blank_o    all segments off
//   invalid_o  pattern is neither a hex glyph nor blank
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       invalid_o
);

    always_comb begin
        nibble_o  = 4'h0;
        blank_o   = 1'b0;
        invalid_o = 1'b0;
        case (seg_i)
            GLYPH_0:     nibble_o = 4'h0;
            GLYPH_1:     nibble_o = 4'h1;
            GLYPH_2:     nibble_o = 4'h2;
            GLYPH_3:     nibble_o = 4'h3;
            GLYPH_4:     nibble_o = 4'h4;
            GLYPH_5:     nibble_o = 4'h5;
            GLYPH_6:     nibble_o = 4'h6;
            GLYPH_7:     nibble_o = 4'h7;
            GLYPH_8:     nibble_o = 4'h8;
            GLYPH_9:     nibble_o = 4'h9;
            GLYPH_A:     nibble_o = 4'hA;
            GLYPH_B:     nibble_o = 4'hB;
            GLYPH_C:     nibble_o = 4'hC;
            GLYPH_D:     nibble_o = 4'hD;
            GLYPH_E:     nibble_o = 4'hE;
            GLYPH_F:     nibble_o = 4'hF;
            GLYPH_BLANK: blank_o  = 1'b1;
            default:     invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_frame_decoder.sv
// Seven-segment scan reader: qualifies each anode dwell, decodes the glyph
// and publishes a full 8-digit frame once every anode has been captured.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   sseg, an     multiplexed display bus, active-low
//   digits       nibble i = digit i of last frame
//   dp/blank/invalid  per-digit flags of last frame
//   frame_valid  one-cycle pulse when the frame outputs update
//   onehot_err   sticky: more than one anode driven at once
//   stale        no frame completed within TIMEOUT_CYCLES
module sseg_frame_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TO_W           = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sseg,
    input  logic [7:0]  an,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  blank,
    output logic [7:0]  invalid,
    output logic        frame_valid,
    output logic        onehot_err,
    output logic        stale
);

    localparam int unsigned ST_W = $clog2(STABLE_CYCLES + 1);

    logic [7:0]      an_q, sseg_q;
    logic [15:0]     prev_q;
    fsm_t            state_q;
    logic [ST_W-1:0] stab_cnt_q;
    logic [31:0]     shadow_digit_q;
    logic [7:0]      shadow_dp_q, shadow_blank_q, shadow_invalid_q;
    logic [7:0]      seen_q;
    logic            pub_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [31:0]     digits_q;
    logic [7:0]      dp_q, blank_q, invalid_q;
    logic            frame_valid_q, onehot_err_q, stale_q;

    logic [7:0] sel;
    logic       multi, act_valid, changed, capture;
    logic [7:0] seen_d;
    logic       pub_d;
    logic [3:0] dec_nibble;
    logic       dec_blank, dec_invalid;

    sseg_glyph_decode u_dec (
        .seg_i     (sseg_q[6:0]),
        .nibble_o  (dec_nibble),
        .blank_o   (dec_blank),
        .invalid_o (dec_invalid)
    );

    // Anode qualification on the registered bus; x & (x-1) != 0 means >1 bit set.
    always_comb begin
        sel       = ~an_q;
        multi     = |(sel & (sel - 8'd1));
        act_valid = (sel != 8'd0) && !multi;
        changed   = ({an_q, sseg_q} != prev_q);
        capture   = (state_q == SETTLE) && act_valid && !changed &&
                    (stab_cnt_q == ST_W'(STABLE_CYCLES - 1));
        // A publish clears seen; a capture in the same cycle lands in the cleared mask.
        seen_d    = (pub_q ? 8'd0 : seen_q) | (capture ? sel : 8'd0);
        pub_d     = capture && (&seen_d);
    end

    // Dwell qualification FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            stab_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act_valid) begin
                        state_q    <= SETTLE;
                        stab_cnt_q <= ST_W'(1);
                    end
                end
                SETTLE: begin
                    if (!act_valid) begin
                        state_q <= IDLE;
                    end else if (changed) begin
                        stab_cnt_q <= ST_W'(1);
                    end else begin
                        stab_cnt_q <= stab_cnt_q + ST_W'(1);
                        if (capture) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_q    <= act_valid ? SETTLE : IDLE;
                        stab_cnt_q <= ST_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Input stage, shadow capture, frame publish, timeout and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q             <= 8'hFF;
            sseg_q           <= 8'hFF;
            prev_q           <= 16'hFFFF;
            shadow_digit_q   <= '0;
            shadow_dp_q      <= '0;
            shadow_blank_q   <= '0;
            shadow_invalid_q <= '0;
            seen_q           <= '0;
            pub_q            <= 1'b0;
            to_cnt_q         <= '0;
            digits_q         <= '0;
            dp_q             <= '0;
            blank_q          <= '0;
            invalid_q        <= '0;
            frame_valid_q    <= 1'b0;
            onehot_err_q     <= 1'b0;
            stale_q          <= 1'b0;
        end else begin
            an_q   <= an;
            sseg_q <= sseg;
            prev_q <= {an_q, sseg_q};

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel[i]) begin
                    shadow_digit_q[i*4 +: 4] <= dec_nibble;
                    shadow_dp_q[i]           <= ~sseg_q[7];
                    shadow_blank_q[i]        <= dec_blank;
                    shadow_invalid_q[i]      <= dec_invalid;
                end
            end
            seen_q <= seen_d;
            pub_q  <= pub_d;

            frame_valid_q <= pub_q;
            if (pub_q) begin
                digits_q  <= shadow_digit_q;
                dp_q      <= shadow_dp_q;
                blank_q   <= shadow_blank_q;
                invalid_q <= shadow_invalid_q;
            end

            if (pub_q) begin
                to_cnt_q <= '0;
                stale_q  <= 1'b0;
            end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
                if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) stale_q <= 1'b1;
            end

            if (multi) onehot_err_q <= 1'b1;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign invalid     = invalid_q;
    assign frame_valid = frame_valid_q;
    assign onehot_err  = onehot_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sseg_frame_decoder.sv
// Scoreboard bench for sseg_frame_decoder: stimulus pushes expected frames,
// a negedge monitor pops and compares on every frame_valid.
module tb_sseg_frame_decoder;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  dp;
        logic [7:0]  bl;
        logic [7:0]  inv;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sseg = 8'hFF;
    logic [7:0]  an = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  dp, blank, invalid;
    logic        frame_valid, onehot_err, stale;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    frame_t sb[$];

    always #5 clk = ~clk;

    sseg_frame_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64),
        .TO_W           (21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sseg        (sseg),
        .an          (an),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .invalid     (invalid),
        .frame_valid (frame_valid),
        .onehot_err  (onehot_err),
        .stale       (stale)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Active-low glyph table, independent of the RTL package.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
        endcase
    endfunction

    // Monitor: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            frame_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got digits %h with no frame expected", digits);
            end else begin
                frame_t e;
                e = sb.pop_front();
                chk("frame_digits", digits, e.d);
                chk("frame_dp", 32'(dp), 32'(e.dp));
                chk("frame_blank", 32'(blank), 32'(e.bl));
                chk("frame_invalid", 32'(invalid), 32'(e.inv));
            end
        end
    end

    task automatic drive(input int idx, input logic [7:0] s, input int cycles);
        an   = ~(8'd1 << idx);
        sseg = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic go_idle(input int cycles);
        an   = 8'hFF;
        sseg = 8'hFF;
        repeat (cycles) @(negedge clk);
    endtask

    // Scan digits hi down to lo, dp off; digit short_idx dwells only 3 cycles.
    task automatic scan(input logic [31:0] v, input int hi, input int lo, input int short_idx);
        for (int i = hi; i >= lo; i--)
            drive(i, {1'b1, glyph(v[i*4 +: 4])}, (i == short_idx) ? 3 : 8);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        an   = 8'hFF;
        sseg = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input logic [7:0] iv);
        frame_t f;
        f.d = d; f.dp = p; f.bl = b; f.inv = iv;
        sb.push_back(f);
    endtask

    initial begin
        int fc;
        bit got;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_digits", digits, 32'h0);
        chk("rst_flags", {8'h0, dp, blank, invalid}, 32'h0);
        chk("rst_status", {29'h0, frame_valid, onehot_err, stale}, 32'h0);

        // Clean scan
        push(32'h01234567, 8'h00, 8'h00, 8'h00);
        scan(32'h01234567, 7, 0, -1);
        go_idle(20);
        chk("t1_frame_seen", 32'(sb.size()), 32'd0);

        // Short dwell on digit 3 blocks the frame; second scan completes it
        do_reset();
        fc = frame_cnt;
        scan(32'h01234567, 7, 0, 3);
        go_idle(20);
        chk("t2_no_frame", 32'(frame_cnt - fc), 32'd0);
        push(32'h01234567, 8'h00, 8'h00, 8'h00);
        scan(32'h01234567, 7, 0, -1);
        go_idle(20);
        chk("t2_frame_seen", 32'(sb.size()), 32'd0);

        // Blank, invalid and decimal point
        do_reset();
        push(32'h01034067, 8'h01, 8'h20, 8'h04);
        drive(7, {1'b1, glyph(4'h0)}, 8);
        drive(6, {1'b1, glyph(4'h1)}, 8);
        drive(5, 8'hFF, 8);
        drive(4, {1'b1, glyph(4'h3)}, 8);
        drive(3, {1'b1, glyph(4'h4)}, 8);
        drive(2, 8'hD5, 8);
        drive(1, {1'b1, glyph(4'h6)}, 8);
        drive(0, {1'b0, glyph(4'h7)}, 8);
        go_idle(20);
        chk("t3_frame_seen", 32'(sb.size()), 32'd0);

        // Multi-hot anodes: sticky error, no capture
        do_reset();
        chk("t4_err_clear", 32'(onehot_err), 32'd0);
        push(32'h01234567, 8'h00, 8'h00, 8'h00);
        scan(32'h01234567, 7, 2, -1);
        an   = 8'hFC;
        sseg = {1'b1, glyph(4'h9)};
        repeat (10) @(negedge clk);
        chk("t4_err_set", 32'(onehot_err), 32'd1);
        scan(32'h01234567, 1, 0, -1);
        go_idle(20);
        chk("t4_frame_seen", 32'(sb.size()), 32'd0);
        chk("t4_err_sticky", 32'(onehot_err), 32'd1);
        do_reset();
        chk("t4_err_rst", 32'(onehot_err), 32'd0);

        // Timeout: stale exactly 64 cycles after the last publish
        push(32'h01234567, 8'h00, 8'h00, 8'h00);
        scan(32'h01234567, 7, 1, -1);
        an   = 8'hFE;
        sseg = {1'b1, glyph(4'h7)};
        got  = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (frame_valid) got = 1'b1;
        end
        chk("t5_frame_wait", 32'(got), 32'd1);
        an   = 8'hFF;
        sseg = 8'hFF;
        chk("t5_stale_clear", 32'(stale), 32'd0);
        repeat (63) @(negedge clk);
        chk("t5_stale_63", 32'(stale), 32'd0);
        @(negedge clk);
        chk("t5_stale_64", 32'(stale), 32'd1);
        chk("t5_digits_kept", digits, 32'h01234567);
        push(32'h76543210, 8'h00, 8'h00, 8'h00);
        scan(32'h76543210, 7, 0, -1);
        go_idle(20);
        chk("t5_frame_seen", 32'(sb.size()), 32'd0);
        chk("t5_stale_cleared", 32'(stale), 32'd0);

        // Reset mid-frame discards partial data
        do_reset();
        scan(32'h01234567, 3, 0, -1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rst_digits", digits, 32'h0);
        chk("t6_rst_valid", 32'(frame_valid), 32'd0);
        rst = 1'b0;
        fc = frame_cnt;
        push(32'h89ABCDEF, 8'h00, 8'h00, 8'h00);
        scan(32'h89ABCDEF, 7, 0, -1);
        go_idle(20);
        chk("t6_frame_count", 32'(frame_cnt - fc), 32'd1);
        chk("t6_frame_seen", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
